// File: rtl/dct4_pkg.sv
// Shared types, mode encodings, default coefficients and the rounding/clamp
// helper for the 4-point streaming DCT/IDCT engine.
package dct4_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_BFLY    = 2'd1,
    S_MAC     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic MODE_DCT  = 1'b0;
  localparam logic MODE_IDCT = 1'b1;

  localparam int C0_DEF = 91;
  localparam int C1_DEF = 118;
  localparam int C3_DEF = 49;

  // Working width of the helper; wide enough for any legal engine configuration.
  localparam int RS_W = 48;

  typedef struct packed {
    logic signed [RS_W-1:0] data;
    logic                   sat;
  } rs_t;

  function automatic rs_t round_sat(input logic signed [RS_W-1:0] value,
                                    input int k, input int out_w);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] biased;
    logic signed [RS_W-1:0] shifted;
    logic signed [RS_W-1:0] max_v;
    logic signed [RS_W-1:0] min_v;
    rs_t r;
    one     = {{(RS_W-1){1'b0}}, 1'b1};
    biased  = value + (one <<< (k - 1));
    shifted = biased >>> k;
    max_v   = (one <<< (out_w - 1)) - one;
    min_v   = -max_v - one;
    r.sat   = 1'b1;
    if (shifted > max_v) begin
      r.data = max_v;
    end else if (shifted < min_v) begin
      r.data = min_v;
    end else begin
      r.data = shifted;
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dct4_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of one MAC sum.
// The shift is SHIFT for the forward transform and SHIFT+1 for the inverse.
module dct4_round_sat
  import dct4_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  value,
  input  logic                    idct,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  rs_t                   r;
  logic [RS_W-OUT_W-1:0] hi_unused;

  always_comb r = round_sat(RS_W'(value), SHIFT + (idct ? 1 : 0), OUT_W);

  // After clamping only the low OUT_W bits carry information.
  assign data      = r.data[OUT_W-1:0];
  assign sat       = r.sat;
  assign hi_unused = r.data[RS_W-1:OUT_W];

endmodule

// File: rtl/dct4_stream_engine.sv
// Streaming 4-point DCT/IDCT: collect 4 samples, butterfly, MAC with
// round/saturate, then drain 4 results under valid/ready backpressure.
module dct4_stream_engine
  import dct4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 7,
  parameter int C0     = C0_DEF,
  parameter int C1     = C1_DEF,
  parameter int C3     = C3_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int BF_W  = DATA_W + 1;
  localparam int MAC_W = DATA_W + COEF_W + 3;

  localparam logic signed [COEF_W-1:0] C0_Q = COEF_W'(C0);
  localparam logic signed [COEF_W-1:0] C1_Q = COEF_W'(C1);
  localparam logic signed [COEF_W-1:0] C3_Q = COEF_W'(C3);
  localparam logic signed [MAC_W-1:0]  K0   = MAC_W'(C0_Q);
  localparam logic signed [MAC_W-1:0]  K1   = MAC_W'(C1_Q);
  localparam logic signed [MAC_W-1:0]  K3   = MAC_W'(C3_Q);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       mode_q, mode_d;
  logic       accept;
  logic       idct;

  logic signed [DATA_W-1:0] x_buf  [4];
  logic signed [BF_W-1:0]   bf_p0  [4];
  logic signed [MAC_W-1:0]  e      [4];
  logic signed [MAC_W-1:0]  sum    [4];
  logic signed [OUT_W-1:0]  rs_data[4];
  logic signed [OUT_W-1:0]  res_p1 [4];
  logic [3:0]               rs_sat;
  logic [3:0]               sat_p1;

  assign accept = in_valid && (state_q == S_COLLECT);
  assign idct   = (mode_q == MODE_IDCT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      mode_q  <= MODE_DCT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) mode_d = mode;
          if (cnt_q == 2'd3) state_d = S_BFLY;
        end
      end
      S_BFLY: state_d = S_MAC;
      S_MAC:  state_d = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Stage p0: butterfly (forward) or pass-through (inverse)
  always_ff @(posedge clk) begin
    if (accept) x_buf[cnt_q] <= in_data;
    if (state_q == S_BFLY) begin
      if (idct) begin
        for (int i = 0; i < 4; i++) bf_p0[i] <= BF_W'(x_buf[i]);
      end else begin
        bf_p0[0] <= BF_W'(x_buf[0]) + BF_W'(x_buf[3]);
        bf_p0[1] <= BF_W'(x_buf[1]) + BF_W'(x_buf[2]);
        bf_p0[2] <= BF_W'(x_buf[0]) - BF_W'(x_buf[3]);
        bf_p0[3] <= BF_W'(x_buf[1]) - BF_W'(x_buf[2]);
      end
    end
    if (state_q == S_MAC) begin
      for (int i = 0; i < 4; i++) res_p1[i] <= rs_data[i];
      sat_p1 <= rs_sat;
    end
  end

  // Stage p1: full-precision MAC feeding the round/saturate units
  always_comb begin
    for (int i = 0; i < 4; i++) e[i] = MAC_W'(bf_p0[i]);
    if (idct) begin
      sum[0] = K0 * e[0] + K1 * e[1] + K0 * e[2] + K3 * e[3];
      sum[1] = K0 * e[0] + K3 * e[1] - K0 * e[2] - K1 * e[3];
      sum[2] = K0 * e[0] - K3 * e[1] - K0 * e[2] + K1 * e[3];
      sum[3] = K0 * e[0] - K1 * e[1] + K0 * e[2] - K3 * e[3];
    end else begin
      sum[0] = K0 * (e[0] + e[1]);
      sum[1] = K1 * e[2] + K3 * e[3];
      sum[2] = K0 * (e[0] - e[1]);
      sum[3] = K3 * e[2] - K1 * e[3];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rs
    dct4_round_sat #(
      .IN_W (MAC_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
    ) u_rs (
      .value(sum[g]),
      .idct (idct),
      .data (rs_data[g]),
      .sat  (rs_sat[g])
    );
  end

  assign out_data = out_valid ? res_p1[idx_q] : '0;
  assign out_idx  = idx_q;
  assign out_last = out_valid && (idx_q == 2'd3);
  assign out_sat  = out_valid && sat_p1[idx_q];
  assign busy     = !((state_q == S_COLLECT) && (cnt_q == 2'd0));

endmodule

// File: tb/tb_dct4_stream_engine.sv
// Scenario bench for dct4_stream_engine: a reference model pushes expected
// results when a block is sent; each scenario pops and compares on output.
module tb_dct4_stream_engine;

  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [7:0] in_data = '0;
  logic in_ready, out_valid, out_last, out_sat, busy;
  logic signed [7:0] out_data;
  logic [1:0] out_idx;

  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;

  typedef int blk_t[4];
  typedef struct {
    logic signed [7:0] data;
    logic [1:0]        idx;
    logic              sat;
  } exp_t;
  exp_t sb[$];

  dct4_stream_engine dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_model(input blk_t x, input logic m);
    int s[4];
    int k, v;
    exp_t t;
    if (!m) begin
      s[0] = 91 * (x[0] + x[1] + x[2] + x[3]);
      s[1] = 118 * (x[0] - x[3]) + 49 * (x[1] - x[2]);
      s[2] = 91 * (x[0] - x[1] - x[2] + x[3]);
      s[3] = 49 * (x[0] - x[3]) - 118 * (x[1] - x[2]);
      k = 7;
    end else begin
      s[0] = 91 * x[0] + 118 * x[1] + 91 * x[2] + 49 * x[3];
      s[1] = 91 * x[0] + 49 * x[1] - 91 * x[2] - 118 * x[3];
      s[2] = 91 * x[0] - 49 * x[1] - 91 * x[2] + 118 * x[3];
      s[3] = 91 * x[0] - 118 * x[1] + 91 * x[2] - 49 * x[3];
      k = 8;
    end
    for (int i = 0; i < 4; i++) begin
      v = (s[i] + (1 << (k - 1))) >>> k;
      t.sat = (v > 127) || (v < -128);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      t.data = v[7:0];
      t.idx  = 2'(i);
      sb.push_back(t);
    end
  endfunction

  task automatic send_block(input blk_t d, input logic m, input int gap, input bit toggle);
    int n;
    push_model(d, m);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          if (toggle) mode = ~m;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d[i][7:0];
      mode     = (i == 0 || !toggle) ? m : ~m;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL accept_timeout slot %0d: in_ready=%0b, required 1", i, in_ready);
      end
      acc_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 2'd0 || out_last !== 1'b0 ||
        out_sat !== 1'b0 || out_data !== 8'sd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%0b v=%0b i=%0d l=%0b s=%0b d=%0d busy=%0b, required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, out_sat, out_data, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dct_basic();
    blk_t b;
    exp_t e;
    int n;
    b = '{2, 16, 2, 16};
    send_block(b, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (k == 0) begin
        tests++;
        if (cyc - acc_cyc !== 3) begin
          fails++;
          $display("FAIL dct_latency: got %0d cycles, required 3", cyc - acc_cyc);
        end
      end
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx ||
          out_sat !== e.sat || out_last !== (e.idx == 2'd3)) begin
        fails++;
        $display("FAIL dct_basic[%0d]: got v=%0b d=%0d i=%0d s=%0b l=%0b, required d=%0d i=%0d s=%0b",
                 k, out_valid, out_data, out_idx, out_sat, out_last, e.data, e.idx, e.sat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idct();
    blk_t b;
    exp_t e;
    int n;
    b = '{26, -8, 0, -18};
    send_block(b, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx ||
          out_sat !== e.sat || out_last !== (e.idx == 2'd3)) begin
        fails++;
        $display("FAIL idct[%0d]: got v=%0b d=%0d i=%0d s=%0b, required d=%0d i=%0d s=%0b",
                 k, out_valid, out_data, out_idx, out_sat, e.data, e.idx, e.sat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    blk_t b;
    exp_t e;
    int n;
    for (int blk = 0; blk < 2; blk++) begin
      b = (blk == 0) ? '{127, 127, 127, 127} : '{-128, -128, -128, -128};
      send_block(b, 1'b0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        tests++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx || out_sat !== e.sat) begin
          fails++;
          $display("FAIL saturation[%0d][%0d]: got d=%0d i=%0d s=%0b, required d=%0d i=%0d s=%0b",
                   blk, k, out_data, out_idx, out_sat, e.data, e.idx, e.sat);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_backpressure();
    blk_t b;
    exp_t e;
    int n;
    b = '{2, 16, 2, 16};
    send_block(b, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      e = sb.pop_front();
      if (k == 1) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'sd99;
        for (int h = 0; h < 5; h++) begin
          tests++;
          if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== 2'd1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold[%0d]: got v=%0b d=%0d i=%0d rdy=%0b, required 1 %0d 1 0",
                     h, out_valid, out_data, out_idx, in_ready, e.data);
          end
          @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      tests++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx || out_sat !== e.sat) begin
        fails++;
        $display("FAIL backpressure[%0d]: got d=%0d i=%0d s=%0b, required d=%0d i=%0d s=%0b",
                 k, out_data, out_idx, out_sat, e.data, e.idx, e.sat);
      end
      @(negedge clk);
    end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_return: rdy=%0b v=%0b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mode_latch();
    blk_t b;
    exp_t e;
    int n;
    for (int blk = 0; blk < 2; blk++) begin
      if (blk == 0) begin
        b = '{26, -8, 0, -18};
        send_block(b, 1'b1, 2, 1'b1);
      end else begin
        b = '{2, 16, 2, 16};
        send_block(b, 1'b0, 3, 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        tests++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx || out_sat !== e.sat) begin
          fails++;
          $display("FAIL mode_latch[%0d][%0d]: got d=%0d i=%0d s=%0b, required d=%0d i=%0d s=%0b",
                   blk, k, out_data, out_idx, out_sat, e.data, e.idx, e.sat);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_round_trip();
    blk_t x, c;
    exp_t e;
    int n, diff;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) x[i] = $urandom_range(64) - 32;
      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 0) send_block(x, 1'b0, 0, 1'b0);
        else send_block(c, 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (!out_valid && n < 50) begin @(negedge clk); n++; end
          e = sb.pop_front();
          tests++;
          if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx) begin
            fails++;
            $display("FAIL round_trip[%0d][%0d][%0d]: got d=%0d i=%0d, required d=%0d i=%0d",
                     r, pass, k, out_data, out_idx, e.data, e.idx);
          end
          if (pass == 0) c[k] = int'(out_data);
          else begin
            diff = int'(out_data) - x[k];
            tests++;
            if (diff > 1 || diff < -1) begin
              fails++;
              $display("FAIL round_trip_err[%0d][%0d]: got %0d, required %0d +/-1", r, k, out_data, x[k]);
            end
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    blk_t b;
    exp_t e;
    int n;
    b = '{2, 16, 2, 16};
    send_block(b, 1'b0, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      e = sb.pop_front();
      tests++;
      if (out_data !== e.data || out_idx !== e.idx) begin
        fails++;
        $display("FAIL reset_mid_pre[%0d]: got d=%0d i=%0d, required d=%0d i=%0d",
                 k, out_data, out_idx, e.data, e.idx);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'sd0) begin
      fails++;
      $display("FAIL reset_mid_async: v=%0b rdy=%0b busy=%0b d=%0d, required 0 1 0 0",
               out_valid, in_ready, busy, out_data);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_release: rdy=%0b v=%0b, required 1 0", in_ready, out_valid);
    end
    send_block(b, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx || out_sat !== e.sat) begin
        fails++;
        $display("FAIL reset_mid_next[%0d]: got d=%0d i=%0d s=%0b, required d=%0d i=%0d s=%0b",
                 k, out_data, out_idx, out_sat, e.data, e.idx, e.sat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_dct_basic();
    test_idct();
    test_saturation();
    test_backpressure();
    test_mode_latch();
    test_round_trip();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct4_stream_engine.md
Name: dct4_stream_engine

Overview:
- Streaming 4-point fixed-point transform engine; generalised successor to the team's fixed-vector DCT/IDCT demo block.
- Accepts signed samples one per handshake and collects blocks of 4.
- Computes either the forward DCT or the inverse DCT, selected per block.
- Returns 4 rounded, saturated results serially with valid/ready backpressure. Sits between the sample source (UART/ROM feeder) and the output/display driver.

Parameters:
- DATA_W, 8, signed input sample width (>=4)
- OUT_W, 8, signed output width (>=4, <=DATA_W+4)
- COEF_W, 8, signed coefficient width (includes sign bit)
- SHIFT, 7, fractional bits of coefficients (Q-format)
- C0, 91, round(cos(pi/4)*2^SHIFT)
- C1, 118, round(cos(pi/8)*2^SHIFT)
- C3, 49, round(cos(3pi/8)*2^SHIFT)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = forward DCT, 1 = IDCT; sampled with the first sample of each block
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- in_data  in  DATA_W  signed sample (DCT) or coefficient (IDCT)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed result
- out_idx  out  2  index 0..3 of out_data within the block
- out_last  out  1  high with out_idx==3
- out_sat  out  1  current out_data was clamped
- busy  out  1  high in any state other than S_COLLECT with count 0

Behaviour:
- Reset (async assert, sync deassert in the clk domain):
  - state = S_COLLECT, sample count = 0
  - in_ready = 1; out_valid, out_idx, out_last, out_sat, out_data and busy all 0
  - partial blocks and pending results are discarded
- FSM: S_COLLECT -> S_BFLY -> S_MAC -> S_DRAIN -> S_COLLECT.
- S_COLLECT:
  - in_ready = 1; on in_valid & in_ready, store the sample at slot cnt and increment cnt.
  - Mode is latched on the cnt==0 accept; changes to mode mid-block are ignored.
  - The accept at cnt==3 moves to S_BFLY.
- S_BFLY, 1 cycle, in_ready = 0:
  - DCT: A0 = x0+x3, A1 = x1+x2, B0 = x0-x3, B1 = x1-x2, each DATA_W+1 bits.
  - IDCT: register the inputs unchanged.
- S_MAC, 1 cycle, full-precision signed products and sums (DATA_W+COEF_W+3 bits, no intermediate truncation):
  - DCT: X0 = C0*(A0+A1), X2 = C0*(A0-A1), X1 = C1*B0 + C3*B1, X3 = C3*B0 - C1*B1.
  - IDCT: y0 = C0*X0 + C1*X1 + C0*X2 + C3*X3; y1 = C0*X0 + C3*X1 - C0*X2 - C1*X3; y2 = C0*X0 - C3*X1 - C0*X2 + C1*X3; y3 = C0*X0 - C1*X1 + C0*X2 - C3*X3.
  - Scaling: K = SHIFT for DCT, SHIFT+1 for IDCT. Result = (sum + 2^(K-1)) >>> K (round half up, arithmetic shift).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; record a per-result sat bit.
- S_DRAIN:
  - out_valid = 1; present results in order idx 0,1,2,3.
  - On out_valid & out_ready, advance the index. The accept at idx 3 (out_last = 1) returns to S_COLLECT with cnt = 0 and out_valid falling on the next cycle.
  - While out_ready = 0, out_data, out_idx, out_last and out_sat hold stable.
- Timing:
  - Latency: 4th input accept at cycle t -> out_valid high at t+3 (1 cycle each in S_BFLY and S_MAC; registered output).
  - Throughput with no backpressure: 1 block per 4 + 2 + 4 = 10 cycles.
  - in_ready = 0 throughout S_BFLY, S_MAC and S_DRAIN; inputs offered then are not consumed.
- Round-trip property: IDCT(DCT(x)) reproduces x within ±1 LSB for |x| <= 2^(DATA_W-3).

Decomposition:
- Package dct4_pkg:
  - state enum (S_COLLECT, S_BFLY, S_MAC, S_DRAIN)
  - mode constants MODE_DCT = 0, MODE_IDCT = 1
  - default coefficient constants C0/C1/C3 for SHIFT = 7
  - function round_sat(value, K, OUT_W) returning data and sat
- One sub-module, dct4_round_sat: combinational round-half-up, shift and clamp. Instantiated 4x in S_MAC's output register path.
- FSM, input buffer, butterfly and MAC remain in dct4_stream_engine.

Test Plan:
- DCT basic: mode = 0, feed 2,16,2,16 with out_ready = 1 -> out 26,-8,0,-18 with idx 0..3, last on -18, sat = 0, first out_valid 3 cycles after the 4th accept.
- IDCT round trip: mode = 1, feed 26,-8,0,-18 -> out 2,16,2,16; out_sat = 0.
- Saturation: mode = 0, feed 127,127,127,127 -> out 127 (sat = 1), 0, 0, 0 (sat = 0); feed -128 x4 -> out -128 (sat = 1), 0, 0, 0.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles at idx 1 -> out_data/out_idx stable and in_ready = 0 throughout.
  - Release -> remaining results in order; in_ready = 1 the cycle after the idx-3 accept.
- Mode latch and in_valid gaps: toggle mode after the 1st sample and insert in_valid = 0 gaps between samples -> block processed in the originally latched mode with results identical to the gap-free run.
- Reset mid-operation:
  - Assert rst during S_DRAIN at idx 2 -> out_valid = 0 immediately (async), in_ready = 1 after release.
  - Next block of 2,16,2,16 -> 26,-8,0,-18 with no stale data.
